// File: rtl/matrix_c_unloader_pkg.sv
// Shared definitions for the SIMD array result path: element and bus sizing
// plus the unloader FSM state encoding.
package matrix_c_unloader_pkg;

  localparam int MCU_WORD_W  = 32;
  localparam int MCU_N_WORDS = 16;
  localparam int MCU_MAT_W   = MCU_WORD_W * MCU_N_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_c_unloader.sv
// Matrix_C unloader: enables the PEs for a fixed number of cycles, captures
// the result bus into a shadow register, then streams the elements out one
// per valid/ready handshake and pulses done at the end.
module matrix_c_unloader
  import matrix_c_unloader_pkg::*;
#(
  parameter int WORD_W      = MCU_WORD_W,
  parameter int N_WORDS     = MCU_N_WORDS,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         start,
  input  logic [WORD_W*N_WORDS-1:0]    Matrix_C,
  output logic                         pe_enable,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_data,
  output logic [$clog2(N_WORDS)-1:0]   out_index,
  output logic                         out_last,
  output logic                         done
);

  localparam int MAT_W = WORD_W * N_WORDS;
  localparam int IDX_W = $clog2(N_WORDS);
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  index_reg;
  logic [MAT_W-1:0]  shadow_reg;
  logic              pe_enable_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic              last_reg;
  logic              done_reg;
  logic              handshake;

  assign handshake = valid_reg && out_ready;

  // Control FSM; every output flag is a register updated alongside the state.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      index_reg     <= '0;
      shadow_reg    <= '0;
      pe_enable_reg <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg     <= ST_WAIT;
            cnt_reg       <= CNT_LOAD;
            index_reg     <= '0;
            pe_enable_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            // Snapshot the result so later bus activity cannot corrupt the stream.
            shadow_reg    <= Matrix_C;
            state_reg     <= ST_STREAM;
            pe_enable_reg <= 1'b0;
            valid_reg     <= 1'b1;
            last_reg      <= (index_reg == LAST_IDX);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_STREAM: begin
          if (handshake) begin
            if (index_reg == LAST_IDX) begin
              // Index stays at its terminal value until the next start.
              state_reg <= ST_DONE;
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              index_reg <= index_reg + 1'b1;
              last_reg  <= (index_reg == LAST_IDX - 1'b1);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Element 0 is the most significant word of the captured bus.
  assign out_data  = valid_reg ? shadow_reg[WORD_W*(N_WORDS-1-int'(index_reg)) +: WORD_W]
                               : '0;
  assign out_index = index_reg;
  assign out_valid = valid_reg;
  assign out_last  = last_reg;
  assign pe_enable = pe_enable_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
